// File: rtl/factorial_pkg.sv
// ---------------------------------------------------------------------------
// factorial_pkg
//   Shared definitions for the iterative factorial unit.
//   - state_t              : controller states (IDLE, CALC, DONE)
//   - FACT_N_W_DEFAULT     : default operand width
//   - FACT_R_W_DEFAULT     : default result width (results are modulo 2^R_W)
// ---------------------------------------------------------------------------
package factorial_pkg;

    localparam int FACT_N_W_DEFAULT = 8;
    localparam int FACT_R_W_DEFAULT = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage : factorial_pkg

// File: rtl/factorial_iter_unit.sv
// ---------------------------------------------------------------------------
// factorial_iter_unit
//   Iterative n! calculator with valid/ready handshakes on both sides.
//   One multiply per clock, counting the operand down from n to 1.
//   The result is n! mod 2^R_W, and a sticky flag records whether any
//   intermediate product spilled past R_W bits.
//
// Ports
//   clk        in   sole clock, rising edge
//   rst        in   asynchronous, active-high reset
//   in_valid   in   operand n is valid
//   in_ready   out  unit can accept an operand (IDLE only)
//   n          in   unsigned operand, N_W bits
//   out_valid  out  result is valid (DONE only)
//   out_ready  in   downstream accepts the result
//   factorial  out  n! mod 2^R_W, registered, holds last result
//   overflow   out  true n! exceeded 2^R_W-1, registered
// ---------------------------------------------------------------------------
module factorial_iter_unit
    import factorial_pkg::*;
#(
    parameter int N_W = FACT_N_W_DEFAULT,
    parameter int R_W = FACT_R_W_DEFAULT
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [N_W-1:0] n,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [R_W-1:0] factorial,
    output logic           overflow
);

    // Full product width: an R_W accumulator times an N_W counter.
    localparam int P_W = R_W + N_W;
    localparam logic [N_W-1:0] CNT_ONE = N_W'(1);
    localparam logic [R_W-1:0] ACC_ONE = R_W'(1);

    state_t         state_reg;
    logic [R_W-1:0] acc_reg;
    logic [N_W-1:0] cnt_reg;
    logic           ovf_reg;

    logic           in_ready_reg;
    logic           out_valid_reg;
    logic [R_W-1:0] factorial_reg;
    logic           overflow_reg;

    logic [P_W-1:0] prod_full;
    logic [R_W-1:0] acc_next;
    logic           ovf_next;

    // Multiply at full width so the bits above R_W are visible; any of them
    // being set means the true factorial no longer fits, and the flag stays
    // set for the rest of the computation.
    always_comb begin
        prod_full = P_W'(acc_reg) * P_W'(cnt_reg);
        acc_next  = prod_full[R_W-1:0];
        ovf_next  = ovf_reg | (|prod_full[P_W-1:R_W]);
    end

    // Single-process controller. Every output is a register so nothing on
    // the input ports reaches an output combinationally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= IDLE;
            acc_reg       <= '0;
            cnt_reg       <= '0;
            ovf_reg       <= 1'b0;
            in_ready_reg  <= 1'b0;
            out_valid_reg <= 1'b0;
            factorial_reg <= '0;
            overflow_reg  <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    // Raised on the first edge after reset and kept high
                    // while waiting; dropped on the accept edge below.
                    in_ready_reg <= 1'b1;
                    if (in_valid && in_ready_reg) begin
                        acc_reg      <= ACC_ONE;
                        cnt_reg      <= n;
                        ovf_reg      <= 1'b0;
                        in_ready_reg <= 1'b0;
                        state_reg    <= CALC;
                    end
                end

                CALC: begin
                    if (cnt_reg > CNT_ONE) begin
                        acc_reg <= acc_next;
                        ovf_reg <= ovf_next;
                        cnt_reg <= cnt_reg - CNT_ONE;
                    end else begin
                        // n=0 and n=1 land here on the first CALC edge with
                        // acc still 1, giving a latency of one edge.
                        factorial_reg <= acc_reg;
                        overflow_reg  <= ovf_reg;
                        out_valid_reg <= 1'b1;
                        state_reg     <= DONE;
                    end
                end

                DONE: begin
                    // Result is held until taken; re-accept cannot happen in
                    // the same cycle because in_ready only rises here.
                    if (out_ready) begin
                        out_valid_reg <= 1'b0;
                        in_ready_reg  <= 1'b1;
                        state_reg     <= IDLE;
                    end
                end

                default: begin
                    state_reg     <= IDLE;
                    in_ready_reg  <= 1'b0;
                    out_valid_reg <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_reg;
    assign out_valid = out_valid_reg;
    assign factorial = factorial_reg;
    assign overflow  = overflow_reg;

endmodule : factorial_iter_unit

// File: tb/tb_factorial_iter_unit.sv
// ---------------------------------------------------------------------------
// tb_factorial_iter_unit
//   Directed bench for factorial_iter_unit (N_W=8, R_W=16). Expected values
//   are hand-computed constants. One line is printed per transaction.
// ---------------------------------------------------------------------------
module tb_factorial_iter_unit;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  n;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] factorial;
    logic        overflow;

    int compared;
    int mismatched;

    factorial_iter_unit #(
        .N_W(8),
        .R_W(16)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .n        (n),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .factorial(factorial),
        .overflow (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Waits (bounded) for in_ready, then runs one operand through the unit.
    // During CALC, in_valid toggles and n changes to prove they are ignored.
    // With hold>0, out_ready stays low that many cycles in DONE first.
    task automatic run_op(input logic [7:0] nv, input int lat, input logic [15:0] fexp,
                          input logic oexp, input int hold);
        int k;
        int edges;
        k = 0;
        while (!in_ready && k < 50) begin
            @(posedge clk); #1; k++;
        end
        check($sformatf("n=%0d in_ready before accept", nv), 32'(in_ready), 32'd1);
        n = nv;
        in_valid = 1'b1;
        @(posedge clk); #1;                  // accept edge
        check($sformatf("n=%0d in_ready after accept", nv), 32'(in_ready), 32'd0);
        edges = 0;
        while (!out_valid && edges < 400) begin
            in_valid = edges[0];
            n = 8'($urandom);
            @(posedge clk); #1;
            edges++;
        end
        in_valid = 1'b0;
        check($sformatf("n=%0d latency", nv), 32'(edges), 32'(lat));
        check($sformatf("n=%0d factorial", nv), 32'(factorial), 32'(fexp));
        check($sformatf("n=%0d overflow", nv), 32'(overflow), 32'(oexp));
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            check($sformatf("n=%0d hold%0d out_valid", nv, h), 32'(out_valid), 32'd1);
            check($sformatf("n=%0d hold%0d factorial", nv, h), 32'(factorial), 32'(fexp));
            check($sformatf("n=%0d hold%0d in_ready", nv, h), 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;                  // handshake edge
        out_ready = 1'b0;
        check($sformatf("n=%0d in_ready after handshake", nv), 32'(in_ready), 32'd1);
        check($sformatf("n=%0d out_valid after handshake", nv), 32'(out_valid), 32'd0);
        $display("op n=%0d latency=%0d factorial=%0h overflow=%0d hold=%0d", nv, edges,
                 factorial, overflow, hold);
    endtask

    initial begin
        int edges;
        compared   = 0;
        mismatched = 0;
        rst        = 1'b1;
        in_valid   = 1'b0;
        out_ready  = 1'b0;
        n          = '0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("reset in_ready", 32'(in_ready), 32'd0);
        check("reset out_valid", 32'(out_valid), 32'd0);
        check("reset factorial", 32'(factorial), 32'd0);
        check("reset overflow", 32'(overflow), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        check("in_ready first cycle after reset", 32'(in_ready), 32'd1);
        $display("op reset released in_ready=%0d", in_ready);

        // Main function and boundary operands
        run_op(8'd5, 5, 16'd120, 1'b0, 0);
        run_op(8'd0, 1, 16'd1, 1'b0, 0);
        run_op(8'd1, 1, 16'd1, 1'b0, 0);
        run_op(8'd8, 8, 16'd40320, 1'b0, 0);
        run_op(8'd9, 9, 16'h8980, 1'b1, 0);
        run_op(8'd4, 4, 16'd24, 1'b0, 10);

        // Asynchronous reset mid-CALC for n=7 (factorial currently 24)
        n = 8'd7;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("async rst in_ready", 32'(in_ready), 32'd0);
        check("async rst out_valid", 32'(out_valid), 32'd0);
        check("async rst factorial", 32'(factorial), 32'd0);
        check("async rst overflow", 32'(overflow), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        check("in_ready after mid-CALC reset", 32'(in_ready), 32'd1);
        $display("op reset mid-CALC n=7 factorial=%0h in_ready=%0d", factorial, in_ready);
        run_op(8'd3, 3, 16'd6, 1'b0, 0);

        // Largest operand: 255! is divisible by 2^16
        run_op(8'd255, 255, 16'd0, 1'b1, 0);

        // Throughput with in_valid and out_ready held high, n=3: 5 cycles/result
        n = 8'd3;
        in_valid = 1'b1;
        out_ready = 1'b1;
        edges = 0;
        while (!out_valid && edges < 50) begin
            @(posedge clk); #1; edges++;
        end
        edges = 0;
        do begin
            @(posedge clk); #1; edges++;
        end while (out_valid && edges < 50);
        while (!out_valid && edges < 50) begin
            @(posedge clk); #1; edges++;
        end
        check("throughput n=3 cycles per result", 32'(edges), 32'd5);
        check("throughput n=3 factorial", 32'(factorial), 32'd6);
        $display("op throughput n=3 cycles=%0d factorial=%0h", edges, factorial);
        in_valid = 1'b0;
        out_ready = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule : tb_factorial_iter_unit
